// File: rtl/ssd_pkg.sv
// ---------------------------------------------------------------------------
// ssd_pkg
// Shared constants and helpers for the seven-segment scan display path.
//   seg_t        : 7-bit active-low segment vector, bit order {a,b,c,d,e,f,g}
//   SEG_OFF      : all segments dark
//   CATH_*       : where the segment field and decimal point sit inside the
//                  8-bit cathode bus {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}
//   hex_to_seg() : hex nibble to active-low segment pattern
// ---------------------------------------------------------------------------
package ssd_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_OFF = 7'h7F;

    localparam int CATH_DP_BIT  = 0;
    localparam int CATH_SEG_LSB = 1;
    localparam int CATH_SEG_MSB = 7;

    function automatic seg_t hex_to_seg(input logic [3:0] nibble);
        seg_t seg;
        case (nibble)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0000100;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b0110001;
            4'hD:    seg = 7'b1000010;
            4'hE:    seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/ssd_hex_decode.sv
// ---------------------------------------------------------------------------
// ssd_hex_decode
// Purely combinational hex-to-seven-segment decoder.
//   nibble_i : 4-bit hex value
//   seg_o    : active-low segments {a,b,c,d,e,f,g}
// ---------------------------------------------------------------------------
module ssd_hex_decode
    import ssd_pkg::*;
(
    input  logic [3:0] nibble_i,
    output seg_t       seg_o
);

    assign seg_o = hex_to_seg(nibble_i);

endmodule

// File: rtl/ssd_scan_ctrl.sv
// ---------------------------------------------------------------------------
// ssd_scan_ctrl
// N-digit multiplexed seven-segment scan controller with a double-buffered,
// frame-synchronous load handshake, leading-zero blanking, per-digit decimal
// points and per-digit blink.
//
// Ports
//   board_clk    : system clock
//   Reset_Pulse  : asynchronous active-high reset
//   Load         : one-cycle request to capture Data_In/Dp_In/Blink_En
//   Data_In      : hex nibbles, digit k at [4k+3:4k], digit N_DIGITS-1 leftmost
//   Dp_In        : decimal point per digit, 1 = lit
//   Blink_En     : blink enable per digit
//   Blank_Lz     : live leading-zero blanking enable
//   Load_Pending : captured data is waiting for the frame boundary
//   Load_Ack     : one-cycle pulse when pending data becomes active
//   An           : active-low anodes, one-hot-low or all ones
//   Cathodes     : active-low {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}
// ---------------------------------------------------------------------------
module ssd_scan_ctrl
    import ssd_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int SCAN_DIV_W   = 18,
    parameter int BLINK_FRAMES = 48
) (
    input  logic                    board_clk,
    input  logic                    Reset_Pulse,
    input  logic                    Load,
    input  logic [4*N_DIGITS-1:0]   Data_In,
    input  logic [N_DIGITS-1:0]     Dp_In,
    input  logic [N_DIGITS-1:0]     Blink_En,
    input  logic                    Blank_Lz,
    output logic                    Load_Pending,
    output logic                    Load_Ack,
    output logic [N_DIGITS-1:0]     An,
    output logic [7:0]              Cathodes
);

    localparam int IDX_W  = $clog2(N_DIGITS);
    localparam int BCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_DIGITS - 1);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BLINK_FRAMES - 1);

    logic [SCAN_DIV_W-1:0]  prescaler_q, prescaler_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [BCNT_W-1:0]      frame_cnt_q, frame_cnt_d;
    logic                   phase_q, phase_d;

    logic [4*N_DIGITS-1:0]  pend_data_q, pend_data_d;
    logic [N_DIGITS-1:0]    pend_dp_q, pend_dp_d;
    logic [N_DIGITS-1:0]    pend_blink_q, pend_blink_d;
    logic [4*N_DIGITS-1:0]  act_data_q, act_data_d;
    logic [N_DIGITS-1:0]    act_dp_q, act_dp_d;
    logic [N_DIGITS-1:0]    act_blink_q, act_blink_d;
    logic                   pending_q, pending_d;
    logic                   ack_q, ack_d;

    logic [N_DIGITS-1:0]    an_q, an_d;
    logic [7:0]             cath_q, cath_d;

    logic                   tick;
    logic                   frame_end;
    logic [IDX_W-1:0]       digit_sel;
    logic [N_DIGITS-1:0]    lz_blank;
    logic [3:0]             sel_nibble;
    logic                   sel_dp;
    logic                   sel_blink;
    logic                   sel_blank;
    seg_t                   sel_seg;

    assign tick      = &prescaler_q;
    assign frame_end = tick && (idx_q == IDX_LAST);

    // Scan starts at the leftmost digit, so slot idx shows digit N-1-idx.
    assign digit_sel = IDX_LAST - idx_q;

    // Prescaler, scan index and blink phase. The blink counter only advances
    // at frame boundaries so a digit never goes dark partway through a frame.
    always_comb begin
        prescaler_d = prescaler_q + 1'b1;
        idx_d       = idx_q;
        frame_cnt_d = frame_cnt_q;
        phase_d     = phase_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        if (frame_end) begin
            if (frame_cnt_q == BCNT_LAST) begin
                frame_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    // Double-buffered load. A Load on the frame_end cycle still lets the
    // previously pending data commit, because the active copy takes the old
    // pending registers while the new capture lands in them.
    always_comb begin
        pend_data_d  = pend_data_q;
        pend_dp_d    = pend_dp_q;
        pend_blink_d = pend_blink_q;
        act_data_d   = act_data_q;
        act_dp_d     = act_dp_q;
        act_blink_d  = act_blink_q;
        if (Load) begin
            pend_data_d  = Data_In;
            pend_dp_d    = Dp_In;
            pend_blink_d = Blink_En;
        end
        if (frame_end && pending_q) begin
            act_data_d  = pend_data_q;
            act_dp_d    = pend_dp_q;
            act_blink_d = pend_blink_q;
        end
        pending_d = Load || (pending_q && !frame_end);
        ack_d     = frame_end && pending_q;
    end

    // A digit is a leading zero when it and every digit to its left are zero.
    // Walking down from the leftmost digit accumulates that condition.
    always_comb begin : lz_calc
        logic higher_zero;
        higher_zero = 1'b1;
        lz_blank    = '0;
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            higher_zero = higher_zero && (act_data_q[4*k +: 4] == 4'h0);
            lz_blank[k] = Blank_Lz && higher_zero;
        end
    end

    always_comb begin
        sel_nibble = 4'h0;
        sel_dp     = 1'b0;
        sel_blink  = 1'b0;
        sel_blank  = 1'b0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (digit_sel == IDX_W'(k)) begin
                sel_nibble = act_data_q[4*k +: 4];
                sel_dp     = act_dp_q[k];
                sel_blink  = act_blink_q[k];
                sel_blank  = lz_blank[k];
            end
        end
    end

    ssd_hex_decode u_hex_decode (
        .nibble_i (sel_nibble),
        .seg_o    (sel_seg)
    );

    // Blinking darkens the anode only; a blanked digit keeps its Dp.
    always_comb begin
        an_d = '1;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (digit_sel == IDX_W'(k)) begin
                an_d[k] = phase_q && sel_blink;
            end
        end
        cath_d                            = 8'hFF;
        cath_d[CATH_SEG_MSB:CATH_SEG_LSB] = sel_blank ? SEG_OFF : sel_seg;
        cath_d[CATH_DP_BIT]               = ~sel_dp;
    end

    always_ff @(posedge board_clk or posedge Reset_Pulse) begin
        if (Reset_Pulse) begin
            prescaler_q  <= '0;
            idx_q        <= '0;
            frame_cnt_q  <= '0;
            phase_q      <= 1'b0;
            pend_data_q  <= '0;
            pend_dp_q    <= '0;
            pend_blink_q <= '0;
            act_data_q   <= '0;
            act_dp_q     <= '0;
            act_blink_q  <= '0;
            pending_q    <= 1'b0;
            ack_q        <= 1'b0;
            an_q         <= '1;
            cath_q       <= 8'hFF;
        end else begin
            prescaler_q  <= prescaler_d;
            idx_q        <= idx_d;
            frame_cnt_q  <= frame_cnt_d;
            phase_q      <= phase_d;
            pend_data_q  <= pend_data_d;
            pend_dp_q    <= pend_dp_d;
            pend_blink_q <= pend_blink_d;
            act_data_q   <= act_data_d;
            act_dp_q     <= act_dp_d;
            act_blink_q  <= act_blink_d;
            pending_q    <= pending_d;
            ack_q        <= ack_d;
            an_q         <= an_d;
            cath_q       <= cath_d;
        end
    end

    assign Load_Pending = pending_q;
    assign Load_Ack     = ack_q;
    assign An           = an_q;
    assign Cathodes     = cath_q;

endmodule
